// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. It allocates tags at issue, captures results from the CDB
// and retires at most one entry per cycle. A mispredicted branch retiring flushes everything.
module reorder_buffer #(
  parameter int ROB_SIZE_BIT = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    issue_valid,
  input  logic [1:0]              issue_type,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_pred_jump,
  output logic                    issue_ready,
  output logic [ROB_SIZE_BIT-1:0] issue_tag,
  input  logic                    cdb_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_tag,
  input  logic [31:0]             cdb_val,
  input  logic                    cdb_jump,
  input  logic [31:0]             cdb_target,
  output logic [4:0]              rob_set_idx,
  output logic [31:0]             rob_set_reg_val,
  output logic [ROB_SIZE_BIT-1:0] rob_set_recorder,
  output logic                    store_commit,
  output logic                    rob_clear,
  output logic [31:0]             rob_clear_pc,
  output logic                    rob_empty
);

  localparam int SIZE = 1 << ROB_SIZE_BIT;
  localparam logic [ROB_SIZE_BIT:0] FULL_COUNT = {1'b1, {ROB_SIZE_BIT{1'b0}}};

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_BRANCH = 2'd1,
    TYPE_STORE  = 2'd2,
    TYPE_RSVD   = 2'd3
  } entry_type_t;

  logic [SIZE-1:0]         busy, busy_next;
  logic [SIZE-1:0]         ready, ready_next;
  logic [SIZE-1:0]         pred_jump;
  logic [SIZE-1:0]         act_jump;
  entry_type_t             etype   [SIZE];
  logic [4:0]              erd     [SIZE];
  logic [31:0]             evalue  [SIZE];
  logic [31:0]             etarget [SIZE];

  logic [ROB_SIZE_BIT-1:0] head, tail;
  logic [ROB_SIZE_BIT:0]   count, count_next;

  logic                    commit_go;
  logic                    mispredict;
  logic                    issue_go;
  logic                    cdb_go;
  entry_type_t             head_type;
  logic                    head_is_reg;

  assign issue_ready = (count != FULL_COUNT);
  assign issue_tag   = tail;
  assign rob_empty   = (count == '0);

  // ready is registered: a result written this cycle can only retire next cycle
  assign head_type   = etype[head];
  assign head_is_reg = (head_type == TYPE_REG) || (head_type == TYPE_RSVD);
  assign commit_go   = (count != '0) && ready[head];
  assign mispredict  = commit_go && (head_type == TYPE_BRANCH) &&
                       (act_jump[head] != pred_jump[head]);
  assign issue_go    = issue_valid && issue_ready && !mispredict;
  assign cdb_go      = cdb_valid && busy[cdb_tag] && !mispredict;

  always_comb begin
    busy_next  = busy;
    ready_next = ready;
    if (cdb_go) ready_next[cdb_tag] = 1'b1;
    if (commit_go) begin
      busy_next[head]  = 1'b0;
      ready_next[head] = 1'b0;
    end
    if (issue_go) begin
      busy_next[tail]  = 1'b1;
      ready_next[tail] = 1'b0;
    end
    if (mispredict) begin
      busy_next  = '0;
      ready_next = '0;
    end
  end

  always_comb begin
    count_next = count;
    case ({issue_go, commit_go})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      ready            <= '0;
      rob_set_idx      <= '0;
      rob_set_reg_val  <= '0;
      rob_set_recorder <= '0;
      store_commit     <= 1'b0;
      rob_clear        <= 1'b0;
      rob_clear_pc     <= '0;
    end else if (rdy_in) begin
      rob_set_idx  <= '0;
      store_commit <= 1'b0;
      rob_clear    <= 1'b0;
      if (commit_go) begin
        rob_set_recorder <= head;
        rob_set_reg_val  <= evalue[head];
        if (head_is_reg) rob_set_idx <= erd[head];
        if (head_type == TYPE_STORE) store_commit <= 1'b1;
        if (mispredict) begin
          rob_clear    <= 1'b1;
          rob_clear_pc <= etarget[head];
        end
      end
      busy  <= busy_next;
      ready <= ready_next;
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (commit_go) head <= head + 1'b1;
        if (issue_go)  tail <= tail + 1'b1;
        count <= count_next;
      end
    end
  end

  // Payload needs no reset: it is only read once the entry is busy and ready.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (issue_go) begin
        etype[tail]     <= entry_type_t'(issue_type);
        erd[tail]       <= issue_rd;
        pred_jump[tail] <= issue_pred_jump;
      end
      if (cdb_go) begin
        evalue[cdb_tag]   <= cdb_val;
        act_jump[cdb_tag] <= cdb_jump;
        etarget[cdb_tag]  <= cdb_target;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a queue-based program-order model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_type = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_pred_jump = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_val = '0;
  logic        cdb_jump = 1'b0;
  logic [31:0] cdb_target = '0;
  logic [4:0]  rob_set_idx;
  logic [31:0] rob_set_reg_val;
  logic [2:0]  rob_set_recorder;
  logic        store_commit;
  logic        rob_clear;
  logic [31:0] rob_clear_pc;
  logic        rob_empty;

  reorder_buffer #(.ROB_SIZE_BIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_jump(issue_pred_jump), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_jump(cdb_jump),
    .cdb_target(cdb_target), .rob_set_idx(rob_set_idx), .rob_set_reg_val(rob_set_reg_val),
    .rob_set_recorder(rob_set_recorder), .store_commit(store_commit), .rob_clear(rob_clear),
    .rob_clear_pc(rob_clear_pc), .rob_empty(rob_empty)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-flight instructions in program order; being in the queue means busy.
  typedef struct {
    int          tag;
    int          typ;
    int          rd;
    bit          pj;
    bit          rdy;
    logic [31:0] val;
    bit          aj;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  int          e_idx, e_rec;
  logic [31:0] e_val, e_cpc;
  bit          e_store, e_clear;

  always @(posedge clk_in or posedge rst_in) begin
    bit   can_issue, do_commit, flush;
    ent_t h, n;
    if (rst_in) begin
      q.delete();
      m_tail = 0; e_idx = 0; e_rec = 0; e_val = 0; e_cpc = 0; e_store = 0; e_clear = 0;
    end else if (rdy_in) begin
      can_issue = q.size() < 8;
      do_commit = q.size() > 0 && q[0].rdy;
      flush = 0; e_idx = 0; e_store = 0; e_clear = 0;
      if (do_commit) begin
        h = q[0];
        e_rec = h.tag;
        e_val = h.val;
        if (h.typ == 0 || h.typ == 3) e_idx = h.rd;
        if (h.typ == 2) e_store = 1;
        if (h.typ == 1 && h.aj != h.pj) begin
          flush = 1; e_clear = 1; e_cpc = h.tgt;
        end
      end
      if (flush) begin
        q.delete();
        m_tail = 0;
      end else begin
        if (cdb_valid)
          foreach (q[i])
            if (q[i].tag == int'(cdb_tag)) begin
              q[i].rdy = 1; q[i].val = cdb_val; q[i].aj = cdb_jump; q[i].tgt = cdb_target;
            end
        if (do_commit) void'(q.pop_front());
        if (issue_valid && can_issue) begin
          n.tag = m_tail; n.typ = int'(issue_type); n.rd = int'(issue_rd);
          n.pj = issue_pred_jump; n.rdy = 0; n.val = 0; n.aj = 0; n.tgt = 0;
          q.push_back(n);
          m_tail = (m_tail + 1) % 8;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("m_issue_ready", issue_ready, q.size() < 8);
      chk("m_issue_tag", issue_tag, m_tail);
      chk("m_empty", rob_empty, q.size() == 0);
      chk("m_set_idx", rob_set_idx, e_idx);
      chk("m_set_val", rob_set_reg_val, e_val);
      chk("m_recorder", rob_set_recorder, e_rec);
      chk("m_store", store_commit, e_store);
      chk("m_clear", rob_clear, e_clear);
      chk("m_clear_pc", rob_clear_pc, e_cpc);
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
  endtask

  task automatic iss(input int t, input int rd, input bit pj);
    issue_valid = 1'b1;
    issue_type = 2'(t);
    issue_rd = 5'(rd);
    issue_pred_jump = pj;
  endtask

  task automatic cdbw(input int tag, input logic [31:0] v, input bit j, input logic [31:0] tgt);
    cdb_valid = 1'b1;
    cdb_tag = 3'(tag);
    cdb_val = v;
    cdb_jump = j;
    cdb_target = tgt;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
  endtask

  initial begin
    cyc();
    chk_en = 1'b1;
    do_reset();
    chk("rst_empty", rob_empty, 1);
    chk("rst_ready", issue_ready, 1);
    chk("rst_tag", issue_tag, 0);
    chk("rst_idx", rob_set_idx, 0);
    chk("rst_clear", rob_clear, 0);

    // single REG round trip
    iss(0, 5, 0); cyc(); idle();
    cdbw(0, 32'h1234, 0, 0); cyc(); idle();
    cyc();
    chk("t1_idx", rob_set_idx, 5);
    chk("t1_val", rob_set_reg_val, 32'h1234);
    chk("t1_rec", rob_set_recorder, 0);
    chk("t1_empty", rob_empty, 1);
    cyc();
    chk("t1_idx_after", rob_set_idx, 0);

    // out-of-order completion, in-order retire (type 3 behaves as REG)
    do_reset();
    iss(0, 1, 0); cyc();
    iss(3, 2, 0); cyc();
    iss(0, 3, 0); cyc(); idle();
    cdbw(2, 32'h22, 0, 0); cyc();
    cdbw(1, 32'h11, 0, 0); cyc();
    cdbw(0, 32'h10, 0, 0); cyc(); idle();
    chk("t2_no_early", rob_set_idx, 0);
    cyc();
    chk("t2_idx1", rob_set_idx, 1); chk("t2_val1", rob_set_reg_val, 32'h10); chk("t2_rec1", rob_set_recorder, 0);
    cyc();
    chk("t2_idx2", rob_set_idx, 2); chk("t2_val2", rob_set_reg_val, 32'h11); chk("t2_rec2", rob_set_recorder, 1);
    cyc();
    chk("t2_idx3", rob_set_idx, 3); chk("t2_val3", rob_set_reg_val, 32'h22); chk("t2_rec3", rob_set_recorder, 2);
    cyc();
    chk("t2_idx_end", rob_set_idx, 0); chk("t2_empty", rob_empty, 1);

    // full buffer, blocked issue, wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      iss(0, i + 1, 0); cyc();
    end
    chk("t3_full", issue_ready, 0);
    chk("t3_tag_wrap", issue_tag, 0);
    iss(0, 9, 0); cyc();
    chk("t3_ninth", issue_ready, 0);
    cdbw(0, 32'hA0, 0, 0); cyc(); cdb_valid = 1'b0;
    cyc();
    chk("t3_commit_idx", rob_set_idx, 1);
    chk("t3_commit_val", rob_set_reg_val, 32'hA0);
    chk("t3_rejected_ready", issue_ready, 1);
    chk("t3_rejected_tag", issue_tag, 0);
    cyc(); idle();
    chk("t3_accept_full", issue_ready, 0);
    chk("t3_accept_tag", issue_tag, 1);
    do_reset();
    chk("t3_midreset_empty", rob_empty, 1);
    chk("t3_midreset_tag", issue_tag, 0);

    // mispredicted branch flushes younger work and a coincident issue/CDB
    do_reset();
    iss(1, 0, 0); cyc();
    iss(0, 7, 0); cyc();
    iss(0, 8, 0); cyc(); idle();
    cdbw(1, 32'h77, 0, 0); cyc();
    cdbw(0, 32'h0, 1, 32'h100); cyc();
    cdbw(2, 32'h88, 0, 0); iss(0, 9, 0); cyc(); idle();
    chk("t4_clear", rob_clear, 1);
    chk("t4_clear_pc", rob_clear_pc, 32'h100);
    chk("t4_empty", rob_empty, 1);
    chk("t4_tag", issue_tag, 0);
    chk("t4_idx", rob_set_idx, 0);
    cyc();
    chk("t4_clear_pulse", rob_clear, 0);
    chk("t4_still_empty", rob_empty, 1);
    repeat (2) cyc();
    iss(0, 3, 0); cyc(); idle();
    chk("t4_next_tag", issue_tag, 1);

    // STORE, REG rd=0, correctly predicted branch
    do_reset();
    iss(2, 0, 0); cyc();
    iss(0, 0, 0); cyc(); idle();
    cdbw(0, 32'hDEAD, 0, 0); cyc();
    cdbw(1, 32'h55, 0, 0); cyc(); idle();
    chk("t5_store", store_commit, 1);
    chk("t5_store_idx", rob_set_idx, 0);
    cyc();
    chk("t5_store_pulse", store_commit, 0);
    chk("t5_rd0_idx", rob_set_idx, 0);
    chk("t5_rd0_val", rob_set_reg_val, 32'h55);
    chk("t5_rd0_rec", rob_set_recorder, 1);
    iss(1, 0, 1); cyc(); idle();
    cdbw(2, 32'h0, 1, 32'h200); cyc(); idle();
    cyc();
    chk("t5_br_ok_clear", rob_clear, 0);
    chk("t5_br_ok_empty", rob_empty, 1);

    // global pause
    do_reset();
    cdbw(5, 32'h99, 0, 0); cyc(); idle();
    iss(0, 4, 0); cyc(); idle();
    cdbw(0, 32'h44, 0, 0); cyc(); idle();
    rdy_in = 1'b0;
    iss(0, 6, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_paused_idx", rob_set_idx, 0);
      chk("t6_paused_tag", issue_tag, 1);
    end
    idle();
    rdy_in = 1'b1;
    cyc();
    chk("t6_idx", rob_set_idx, 4);
    chk("t6_val", rob_set_reg_val, 32'h44);
    chk("t6_empty", rob_empty, 1);
    rdy_in = 1'b0;
    cyc();
    chk("t6_hold_idx", rob_set_idx, 4);
    rdy_in = 1'b1;
    cyc();
    chk("t6_release_idx", rob_set_idx, 0);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
